// File: rtl/io_pkg.sv
// Shared definitions for the board I/O MMIO bridge:
// register offsets, STATUS bit positions, FSM states.
package io_pkg;

    localparam logic [3:0] OFF_LED    = 4'h0;
    localparam logic [3:0] OFF_DPLY   = 4'h4;
    localparam logic [3:0] OFF_SWITCH = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int ST_CHG    = 0;
    localparam int ST_IRQ_EN = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/io_mmio_bridge_switch_debounce.sv
// Switch debouncer: 2-flop synchronizer plus stability counter.
// The change pulse port exists only when IO_SWITCH_IRQ_EN is defined.
module switch_debounce #(
    parameter int WIDTH           = 12,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_raw,
`ifdef IO_SWITCH_IRQ_EN
    output logic             o_chg,
`endif
    output logic [WIDTH-1:0] o_val
);

    localparam logic [15:0] CMAX = 16'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] s1, s2, cand;
    logic [15:0]      cnt;
    logic             accept;

    assign accept = (cnt == CMAX) && (cand != o_val);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1    <= '0;
            s2    <= '0;
            cand  <= '0;
            cnt   <= '0;
            o_val <= '0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
            // any movement of the synchronized input restarts the count
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != CMAX) begin
                cnt <= cnt + 16'd1;
            end
            if (accept) o_val <= cand;
        end
    end

`ifdef IO_SWITCH_IRQ_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstn) o_chg <= 1'b0;
        else         o_chg <= accept;
    end
`endif

endmodule

// File: rtl/io_mmio_bridge.sv
// MMIO bridge to LEDs, display word and debounced switches.
// Define IO_SWITCH_IRQ_EN to enable the switch-change interrupt.
module io_mmio_bridge #(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wstrb,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_led,
    output logic [31:0] o_dply,
    input  logic [11:0] i_switch,
    output logic        o_irq
);
    import io_pkg::*;

    state_t      state_q, state_d;
    logic        q_we;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_wstrb;
    logic [11:0] sw_val;
    logic [31:0] off, rd, status_rd;
    logic        in_win, misal, acc_err, do_wr;
    logic        sel_led, sel_dply, sel_sw, sel_st;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (i_req_valid) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   if (i_rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign o_req_ready = i_rstn && (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            q_we    <= 1'b0;
            q_addr  <= '0;
            q_wdata <= '0;
            q_wstrb <= '0;
        end else if (state_q == S_IDLE && i_req_valid) begin
            q_we    <= i_req_we;
            q_addr  <= i_req_addr;
            q_wdata <= i_req_wdata;
            q_wstrb <= i_req_wstrb;
        end
    end

    assign off      = q_addr - BASE_ADDR;
    assign in_win   = (q_addr >= BASE_ADDR) && (off < 32'd16);
    assign misal    = (q_addr[1:0] != 2'b00);
    assign sel_led  = in_win && (off[3:0] == OFF_LED);
    assign sel_dply = in_win && (off[3:0] == OFF_DPLY);
    assign sel_sw   = in_win && (off[3:0] == OFF_SWITCH);
    assign sel_st   = in_win && (off[3:0] == OFF_STATUS);
    assign acc_err  = !in_win || misal || (q_we && sel_sw);
    assign do_wr    = (state_q == S_ACCESS) && q_we && !acc_err;

    always_comb begin
        rd = '0;
        unique case (1'b1)
            sel_led:  rd = o_led;
            sel_dply: rd = o_dply;
            sel_sw:   rd = {20'b0, sw_val};
            sel_st:   rd = status_rd;
            default:  rd = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_led       <= '0;
            o_dply      <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (do_wr && sel_led)  o_led  <= apply_strb(o_led, q_wdata, q_wstrb);
            if (do_wr && sel_dply) o_dply <= apply_strb(o_dply, q_wdata, q_wstrb);
            if (state_q == S_ACCESS) begin
                o_rsp_err   <= acc_err;
                o_rsp_rdata <= (q_we || acc_err) ? 32'd0 : rd;
            end
        end
    end

`ifdef IO_SWITCH_IRQ_EN
    logic sw_chg, chg_q, chg_d, irq_en_q, irq_en_d, irq_q;

    // a change pulse beats a simultaneous W1C
    always_comb begin
        chg_d    = chg_q;
        irq_en_d = irq_en_q;
        if (do_wr && sel_st) begin
            if (q_wstrb[0] && q_wdata[ST_CHG]) chg_d = 1'b0;
            if (q_wstrb[1]) irq_en_d = q_wdata[ST_IRQ_EN];
        end
        if (sw_chg) chg_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            chg_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            chg_q    <= chg_d;
            irq_en_q <= irq_en_d;
            irq_q    <= chg_d && irq_en_d;
        end
    end

    always_comb begin
        status_rd            = '0;
        status_rd[ST_CHG]    = chg_q;
        status_rd[ST_IRQ_EN] = irq_en_q;
    end

    assign o_irq = irq_q;
`else
    assign status_rd = '0;
    assign o_irq     = 1'b0;
`endif

    switch_debounce #(
        .WIDTH          (12),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .i_raw (i_switch),
`ifdef IO_SWITCH_IRQ_EN
        .o_chg (sw_chg),
`endif
        .o_val (sw_val)
    );

endmodule

// File: tb/tb_io_mmio_bridge.sv
// Directed bench for io_mmio_bridge: vector table plus
// hand sequences for debounce, IRQ, stalls and reset abort.
module tb_io_mmio_bridge;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_req_valid, i_req_we, i_rsp_ready;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [3:0]  i_req_wstrb;
    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_irq;
    logic [31:0] o_rsp_rdata, o_led, o_dply;
    logic [11:0] i_switch;

    int n_vec = 0;
    int n_bad = 0;

    io_mmio_bridge #(
        .BASE_ADDR      (32'h1000_0000),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err  (o_rsp_err),
        .o_led      (o_led),
        .o_dply     (o_dply),
        .i_switch   (i_switch),
        .o_irq      (o_irq)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_led;
        logic [31:0] exp_dply;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge with the bridge idle.
    task automatic do_req(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er);
        chk("req_ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
        i_req_wstrb = s;
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("rsp_valid_n1", 32'(o_rsp_valid), 32'd0);
        @(posedge i_clk); #1;
        chk("rsp_valid_n2", 32'(o_rsp_valid), 32'd1);
        rd = o_rsp_rdata;
        er = o_rsp_err;
        @(posedge i_clk); #1;
        chk("rsp_valid_done", 32'(o_rsp_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    logic [31:0] led_n2;

    initial begin
        vt[0]  = '{1'b1, 32'h1000_0000, 32'h0000_03FF, 4'hF, 32'h0, 1'b0, 32'h0000_03FF, 32'h0};
        vt[1]  = '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 32'h0000_03FF, 1'b0, 32'h0000_03FF, 32'h0};
        vt[2]  = '{1'b1, 32'h1000_0004, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0, 32'h0000_03FF, 32'h00BB_00DD};
        vt[3]  = '{1'b0, 32'h1000_0004, 32'h0,         4'h0, 32'h00BB_00DD, 1'b0, 32'h0000_03FF, 32'h00BB_00DD};
        vt[4]  = '{1'b1, 32'h1000_0004, 32'h1122_3344, 4'h0, 32'h0, 1'b0, 32'h0000_03FF, 32'h00BB_00DD};
        vt[5]  = '{1'b1, 32'h1000_0004, 32'h1122_3344, 4'hA, 32'h0, 1'b0, 32'h0000_03FF, 32'h11BB_33DD};
        vt[6]  = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 32'h0, 1'b1, 32'h0000_03FF, 32'h11BB_33DD};
        vt[7]  = '{1'b1, 32'h1000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 32'h0000_03FF, 32'h11BB_33DD};
        vt[8]  = '{1'b0, 32'h1000_0002, 32'h0,         4'h0, 32'h0, 1'b1, 32'h0000_03FF, 32'h11BB_33DD};
        vt[9]  = '{1'b1, 32'h0FFF_FFFC, 32'h1,         4'hF, 32'h0, 1'b1, 32'h0000_03FF, 32'h11BB_33DD};
        vt[10] = '{1'b1, 32'h1000_0001, 32'h1,         4'hF, 32'h0, 1'b1, 32'h0000_03FF, 32'h11BB_33DD};
        vt[11] = '{1'b0, 32'h1000_0008, 32'h0,         4'h0, 32'h0, 1'b0, 32'h0000_03FF, 32'h11BB_33DD};
        vt[12] = '{1'b0, 32'h1000_000C, 32'h0,         4'h0, 32'h0, 1'b0, 32'h0000_03FF, 32'h11BB_33DD};
        vt[13] = '{1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'h2, 32'h0, 1'b0, 32'h0000_BEFF, 32'h11BB_33DD};

        i_rstn = 1'b0;
        i_req_valid = 1'b0;
        i_req_we = 1'b0;
        i_req_addr = '0;
        i_req_wdata = '0;
        i_req_wstrb = '0;
        i_rsp_ready = 1'b0;
        i_switch = '0;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_led", o_led, 32'h0);
        chk("rst_dply", o_dply, 32'h0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_irq", 32'(o_irq), 32'd0);
        i_rstn = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 14; i++) begin
            do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_led", i), o_led, vt[i].exp_led);
            chk($sformatf("v%0d_dply", i), o_dply, vt[i].exp_dply);
        end

        // LED write visible exactly two cycles after handshake
        i_req_valid = 1'b1; i_req_we = 1'b1;
        i_req_addr = 32'h1000_0000; i_req_wdata = 32'h0000_1234;
        i_req_wstrb = 4'h3; i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("lat_led_n1", o_led, 32'h0000_BEFF);
        @(posedge i_clk); #1;
        led_n2 = o_led;
        chk("lat_led_n2", led_n2, 32'h0000_1234);
        @(posedge i_clk); #1;

        // stalled response holds; new requests ignored meanwhile
        i_req_valid = 1'b1; i_req_we = 1'b0;
        i_req_addr = 32'h1000_0010; i_rsp_ready = 1'b0;
        @(posedge i_clk); #1;
        i_req_we = 1'b1; i_req_addr = 32'h1000_0000;
        i_req_wdata = 32'h77; i_req_wstrb = 4'hF;
        @(posedge i_clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(o_rsp_valid), 32'd1);
            chk("hold_rdata", o_rsp_rdata, 32'h0);
            chk("hold_err", 32'(o_rsp_err), 32'd1);
            chk("hold_req_ready", 32'(o_req_ready), 32'd0);
            @(posedge i_clk); #1;
        end
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("hold_released", 32'(o_rsp_valid), 32'd0);
        chk("hold_led_kept", o_led, 32'h0000_1234);

        // 5-cycle glitch must not be accepted
        i_switch = 12'hA5A;
        repeat (5) @(posedge i_clk);
        #1;
        i_switch = 12'h000;
        repeat (25) @(posedge i_clk);
        #1;
        do_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, rd, er);
        chk("glitch_sw", rd, 32'h0);
        do_req(1'b0, 32'h1000_000C, 32'h0, 4'h0, rd, er);
        chk("glitch_status", rd, 32'h0);

        i_switch = 12'hA5A;
        repeat (30) @(posedge i_clk);
        #1;
        do_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, rd, er);
        chk("deb_sw", rd, 32'h0000_0A5A);
        do_req(1'b0, 32'h1000_000C, 32'h0, 4'h0, rd, er);
`ifdef IO_SWITCH_IRQ_EN
        chk("deb_status", rd, 32'h0000_0001);
        chk("irq_off", 32'(o_irq), 32'd0);

        // enable IRQ, CHG already pending
        i_req_valid = 1'b1; i_req_we = 1'b1;
        i_req_addr = 32'h1000_000C; i_req_wdata = 32'h100;
        i_req_wstrb = 4'hF; i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("irq_on_n2", 32'(o_irq), 32'd1);
        @(posedge i_clk); #1;

        // W1C with IRQ_EN kept
        i_req_valid = 1'b1; i_req_wdata = 32'h101;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("irq_clr_n2", 32'(o_irq), 32'd0);
        @(posedge i_clk); #1;
        do_req(1'b0, 32'h1000_000C, 32'h0, 4'h0, rd, er);
        chk("clr_status", rd, 32'h0000_0100);

        // change pulse lands in the same cycle as a W1C access
        i_switch = 12'h123;
        repeat (19) @(posedge i_clk);
        #1;
        do_req(1'b1, 32'h1000_000C, 32'h101, 4'hF, rd, er);
        chk("coinc_irq", 32'(o_irq), 32'd1);
        do_req(1'b0, 32'h1000_000C, 32'h0, 4'h0, rd, er);
        chk("coinc_status", rd, 32'h0000_0101);
        do_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, rd, er);
        chk("coinc_sw", rd, 32'h0000_0123);
`else
        chk("deb_status", rd, 32'h0);
        do_req(1'b1, 32'h1000_000C, 32'h101, 4'hF, rd, er);
        chk("st_wr_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h1000_000C, 32'h0, 4'h0, rd, er);
        chk("st_readback", rd, 32'h0);
        chk("irq_tied", 32'(o_irq), 32'd0);
`endif

        // reset during ACCESS aborts the write and the response
        i_req_valid = 1'b1; i_req_we = 1'b1;
        i_req_addr = 32'h1000_0000; i_req_wdata = 32'h55;
        i_req_wstrb = 4'hF; i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge i_clk); #1;
            chk("abort_led", o_led, 32'h0);
            chk("abort_rsp", 32'(o_rsp_valid), 32'd0);
            chk("abort_ready", 32'(o_req_ready), 32'd0);
        end
        i_rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("post_rsp", 32'(o_rsp_valid), 32'd0);
            chk("post_led", o_led, 32'h0);
        end
        do_req(1'b1, 32'h1000_0000, 32'h66, 4'hF, rd, er);
        chk("after_rst_led", o_led, 32'h66);
        chk("after_rst_err", 32'(er), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
